onehot_index_table: RTL and testbench

Stateful index-to-one-hot decoder: the inverse of the `priority_encoder`. It holds a `NUM_WIRE`-bit occupancy bitmap in which bits are set and cleared by binary index. It is the natural producer of the `wire_in` vector a `priority_encoder` consumes, for example a register scoreboard or a free-slot table. Set and clear requests are decoded and applied each clock, and the block reports occupancy count, full and empty status, and duplicate-set errors.

---
 rtl/onehot_index_table_pkg.sv | 7 +
 rtl/onehot_index_table_index_decoder.sv | 21 ++
 rtl/onehot_index_table.sv | 99 +++++++++
 tb/tb_onehot_index_table.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_index_table_pkg.sv
// rtl/onehot_index_table_pkg.sv - shared defaults for the onehot_index_table slice
package onehot_index_table_pkg;

  // Default bitmap width, used when the parent does not override NUM_WIRE
  localparam int DEFAULT_NUM_WIRE = 16;

endpackage

// File: rtl/onehot_index_table_index_decoder.sv
// rtl/onehot_index_table_index_decoder.sv - combinational binary index to one-hot decoder
module index_decoder
  import onehot_index_table_pkg::*;
#(
  parameter int NUM_WIRE = DEFAULT_NUM_WIRE,
  parameter int IW       = $clog2(NUM_WIRE)
) (
  input  logic [IW-1:0]       index_i,
  input  logic                index_valid_i,
  output logic [NUM_WIRE-1:0] onehot_o
);

  // An index with no matching bit (>= NUM_WIRE) decodes to all zeros
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_WIRE; i++) begin
      onehot_o[i] = index_valid_i && (index_i == IW'(i));
    end
  end

endmodule

// File: rtl/onehot_index_table.sv
// rtl/onehot_index_table.sv - occupancy bitmap set/cleared by index; err_o under ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
module onehot_index_table
  import onehot_index_table_pkg::*;
#(
  parameter int NUM_WIRE = DEFAULT_NUM_WIRE,
  parameter int IW       = $clog2(NUM_WIRE),
  parameter int CW       = $clog2(NUM_WIRE + 1)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [IW-1:0]       set_index_i,
  input  logic                set_valid_i,
  input  logic [IW-1:0]       clr_index_i,
  input  logic                clr_valid_i,
  input  logic                flush_i,
  output logic [NUM_WIRE-1:0] bitmap_o,
  output logic [CW-1:0]       count_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                set_dup_o
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
  ,
  output logic                err_o
`endif
);

  logic [NUM_WIRE-1:0] set_oh;
  logic [NUM_WIRE-1:0] clr_oh;
  logic [NUM_WIRE-1:0] bitmap_next;
  logic [CW-1:0]       count_next;
  logic                dup_next;

  function automatic logic [CW-1:0] popcount(input logic [NUM_WIRE-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_WIRE; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  index_decoder #(
    .NUM_WIRE (NUM_WIRE),
    .IW       (IW)
  ) u_set_dec (
    .index_i       (set_index_i),
    .index_valid_i (set_valid_i),
    .onehot_o      (set_oh)
  );

  index_decoder #(
    .NUM_WIRE (NUM_WIRE),
    .IW       (IW)
  ) u_clr_dec (
    .index_i       (clr_index_i),
    .index_valid_i (clr_valid_i),
    .onehot_o      (clr_oh)
  );

  // Next bitmap: flush dominates; set is ORed after the clear so set wins on a shared index
  always_comb begin
    bitmap_next = '0;
    dup_next    = 1'b0;
    if (!flush_i) begin
      bitmap_next = (bitmap_o & ~clr_oh) | set_oh;
      dup_next    = |(set_oh & bitmap_o & ~clr_oh);
    end
    count_next = popcount(bitmap_next);
  end

  // Bitmap, count and status flags update together so they never disagree
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      bitmap_o  <= '0;
      count_o   <= '0;
      empty_o   <= 1'b1;
      full_o    <= 1'b0;
      set_dup_o <= 1'b0;
    end else begin
      bitmap_o  <= bitmap_next;
      count_o   <= count_next;
      empty_o   <= (count_next == '0);
      full_o    <= (count_next == CW'(NUM_WIRE));
      set_dup_o <= dup_next;
    end
  end

`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
  // A valid request that decodes to nothing was out of range; latch it until reset
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_o <= 1'b0;
    end else if ((set_valid_i && ~|set_oh) || (clr_valid_i && ~|clr_oh)) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_onehot_index_table.sv
// tb/tb_onehot_index_table.sv - self-checking bench for onehot_index_table
module tb_onehot_index_table;

  localparam int N   = 16;
  localparam int IW  = 4;
  localparam int CW  = 5;
  localparam int N2  = 12;
  localparam int IW2 = 4;
  localparam int CW2 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] set_index, clr_index;
  logic          set_valid, clr_valid, flush;
  logic [N-1:0]  bitmap;
  logic [CW-1:0] count;
  logic          empty, full, set_dup;

  logic [IW2-1:0] set_index2, clr_index2;
  logic           set_valid2, clr_valid2, flush2;
  logic [N2-1:0]  bitmap2;
  logic [CW2-1:0] count2;
  logic           empty2, full2, set_dup2;
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
  logic           err1, err2;
`endif

  int vectors     = 0;
  int miscompares = 0;

  bit occ  [N];
  bit occ2 [N2];
  bit dup_ref;
  bit err2_ref;

  typedef struct {
    bit          sv;
    int          si;
    bit          cv;
    int          ci;
    bit          fl;
    logic [15:0] exp_bitmap;
    int          exp_count;
    bit          exp_dup;
  } vec_t;

  vec_t table_v [10];

  always #5 clk = ~clk;

  onehot_index_table #(.NUM_WIRE(N)) dut (
    .clk_i       (clk),
    .arst_i      (rst),
    .set_index_i (set_index),
    .set_valid_i (set_valid),
    .clr_index_i (clr_index),
    .clr_valid_i (clr_valid),
    .flush_i     (flush),
    .bitmap_o    (bitmap),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full),
    .set_dup_o   (set_dup)
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
    ,
    .err_o       (err1)
`endif
  );

  onehot_index_table #(.NUM_WIRE(N2)) dut2 (
    .clk_i       (clk),
    .arst_i      (rst),
    .set_index_i (set_index2),
    .set_valid_i (set_valid2),
    .clr_index_i (clr_index2),
    .clr_valid_i (clr_valid2),
    .flush_i     (flush2),
    .bitmap_o    (bitmap2),
    .count_o     (count2),
    .empty_o     (empty2),
    .full_o      (full2),
    .set_dup_o   (set_dup2)
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
    ,
    .err_o       (err2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_bitmap();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = occ[i];
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(occ[i]);
    return c;
  endfunction

  function automatic logic [N2-1:0] model_bitmap2();
    logic [N2-1:0] v;
    for (int i = 0; i < N2; i++) v[i] = occ2[i];
    return v;
  endfunction

  // Drive one request cycle into dut, advance the reference, land on the next negedge
  task automatic apply(input bit sv, input int si, input bit cv, input int ci, input bit fl);
    bit was_set;
    set_valid = sv; set_index = IW'(si);
    clr_valid = cv; clr_index = IW'(ci);
    flush     = fl;
    @(posedge clk);
    dup_ref = 1'b0;
    if (fl) begin
      foreach (occ[i]) occ[i] = 1'b0;
    end else begin
      was_set = (sv && si < N) ? occ[si] : 1'b0;
      if (cv && ci < N) occ[ci] = 1'b0;
      if (sv && si < N) begin
        occ[si] = 1'b1;
        dup_ref = was_set && !(cv && ci == si);
      end
    end
    @(negedge clk);
    set_valid = 1'b0; clr_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int c;
    c = model_count();
    chk({tag, ".bitmap"}, 32'(bitmap), 32'(model_bitmap()));
    chk({tag, ".count"},  32'(count),  32'(c));
    chk({tag, ".empty"},  32'(empty),  32'(c == 0));
    chk({tag, ".full"},   32'(full),   32'(c == N));
    chk({tag, ".dup"},    32'(set_dup), 32'(dup_ref));
  endtask

  task automatic apply2(input bit sv, input int si, input bit cv, input int ci);
    set_valid2 = sv; set_index2 = IW2'(si);
    clr_valid2 = cv; clr_index2 = IW2'(ci);
    @(posedge clk);
    if ((sv && si >= N2) || (cv && ci >= N2)) err2_ref = 1'b1;
    if (cv && ci < N2) occ2[ci] = 1'b0;
    if (sv && si < N2) occ2[si] = 1'b1;
    @(negedge clk);
    set_valid2 = 1'b0; clr_valid2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_valid = 0; set_index = '0; clr_valid = 0; clr_index = '0; flush = 0;
    set_valid2 = 0; set_index2 = '0; clr_valid2 = 0; clr_index2 = '0; flush2 = 0;
    foreach (occ[i]) occ[i] = 1'b0;
    foreach (occ2[i]) occ2[i] = 1'b0;
    dup_ref = 0; err2_ref = 0;

    table_v[0] = '{1, 3, 0, 0, 0, 16'h0008, 1, 0};
    table_v[1] = '{1, 7, 1, 3, 0, 16'h0080, 1, 0};
    table_v[2] = '{1, 4, 1, 4, 0, 16'h0090, 2, 0};
    table_v[3] = '{1, 4, 0, 0, 0, 16'h0090, 2, 1};
    table_v[4] = '{0, 0, 1, 9, 0, 16'h0090, 2, 0};
    table_v[5] = '{1, 5, 0, 0, 0, 16'h00B0, 3, 0};
    table_v[6] = '{1, 6, 0, 0, 0, 16'h00F0, 4, 0};
    table_v[7] = '{1, 2, 0, 0, 1, 16'h0000, 0, 0};
    table_v[8] = '{1, 15, 0, 0, 0, 16'h8000, 1, 0};
    table_v[9] = '{1, 0, 1, 15, 0, 16'h0001, 1, 0};

    repeat (2) @(negedge clk);
    chk("rst.bitmap", 32'(bitmap), 32'h0);
    chk("rst.count",  32'(count),  32'h0);
    chk("rst.empty",  32'(empty),  32'h1);
    chk("rst.full",   32'(full),   32'h0);
    chk("rst.dup",    32'(set_dup), 32'h0);
    rst = 1'b0;

    // Directed table
    for (int k = 0; k < 10; k++) begin
      apply(table_v[k].sv, table_v[k].si, table_v[k].cv, table_v[k].ci, table_v[k].fl);
      chk($sformatf("tbl%0d.bitmap", k), 32'(bitmap), 32'(table_v[k].exp_bitmap));
      chk($sformatf("tbl%0d.count", k),  32'(count),  32'(table_v[k].exp_count));
      chk($sformatf("tbl%0d.empty", k),  32'(empty),  32'(table_v[k].exp_count == 0));
      chk($sformatf("tbl%0d.dup", k),    32'(set_dup), 32'(table_v[k].exp_dup));
      check_model($sformatf("tbl%0d.model", k));
    end

    // Fill to full, then duplicate set at a full table
    apply(0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) apply(1, i, 0, 0, 0);
    chk("fill.bitmap", 32'(bitmap), 32'h0000FFFF);
    chk("fill.count",  32'(count),  32'd16);
    chk("fill.full",   32'(full),   32'h1);
    chk("fill.dup",    32'(set_dup), 32'h0);
    apply(1, 5, 0, 0, 0);
    chk("dup.pulse",   32'(set_dup), 32'h1);
    chk("dup.bitmap",  32'(bitmap), 32'h0000FFFF);
    chk("dup.full",    32'(full),   32'h1);
    apply(0, 0, 0, 0, 0);
    chk("dup.onecycle", 32'(set_dup), 32'h0);

    // Random stream against the reference model
    for (int n = 0; n < 1000; n++) begin
      apply(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
            ($urandom_range(0, 49) == 0));
      check_model($sformatf("rnd%0d", n));
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
      chk("rnd.err_pow2", 32'(err1), 32'h0);
`endif
    end

    // Out-of-range index on a 12-wide table is dropped
    apply2(1, 3, 0, 0);
    chk("rng.pre", 32'(bitmap2), 32'(model_bitmap2()));
    apply2(1, 13, 0, 0);
    chk("rng.bitmap", 32'(bitmap2), 32'h008);
    chk("rng.count",  32'(count2),  32'd1);
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
    chk("rng.err", 32'(err2), 32'(err2_ref));
`endif
    apply2(1, 11, 1, 14);
    chk("rng.bitmap2", 32'(bitmap2), 32'h808);
    chk("rng.full",    32'(full2),   32'h0);
    apply2(0, 0, 0, 0);
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
    chk("rng.err_hold", 32'(err2), 32'h1);
`endif

    // Asynchronous reset mid-cycle with the bitmap populated
    apply(1, 2, 0, 0, 0);
    apply(1, 10, 0, 0, 0);
    chk("pre_rst.nonempty", 32'(empty), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst.bitmap", 32'(bitmap), 32'h0);
    chk("arst.count",  32'(count),  32'h0);
    chk("arst.empty",  32'(empty),  32'h1);
    chk("arst.full",   32'(full),   32'h0);
    chk("arst.bitmap2", 32'(bitmap2), 32'h0);
`ifdef ONEHOT_INDEX_TABLE_RANGE_CHECK_EN
    chk("arst.err2", 32'(err2), 32'h0);
`endif
    foreach (occ[i]) occ[i] = 1'b0;
    dup_ref = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply(1, 9, 0, 0, 0);
    chk("post_rst.bitmap", 32'(bitmap), 32'h0200);
    check_model("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
